// File: rtl/text_pkg.sv
// Shared constants, control codes and FSM encoding for the text_term terminal buffer.
package text_pkg;

  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int CELLS = COLS * ROWS;

  localparam logic [7:0] FILL  = 8'h20;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_BS = 8'h08;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    CLR_ROW
  } state_e;

  // row * COLS as shift-and-add, so no multiplier is inferred
  function automatic logic [10:0] row_off(input logic [4:0] row);
    logic [10:0] r;
    r = {6'd0, row};
    return (r << 6) + (r << 4);
  endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character RAM: one write port, one registered read-first read port.
module text_ram #(
  parameter int DEPTH = 2000,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: no reset on the array or its read register; a reset here would stop block-RAM inference.
  // NOTE: non-blocking assignments make the read see the pre-write contents (read-first).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/text_term.sv
// Character-cell terminal buffer: byte stream in, 80x25 RAM with cursor, wrap and hardware scroll.
// Optional block cursor on the read port when TEXT_TERM_CURSOR_EN is defined.
module text_term
  import text_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [10:0] pos,
  output logic [7:0]  char,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y
);

  state_e      state_q, state_d;
  logic [6:0]  cur_x_q, cur_x_d;
  logic [4:0]  cur_y_q, cur_y_d;
  logic [4:0]  top_q, top_d;
  logic [10:0] clr_addr_q, clr_addr_d;
  logic [10:0] clr_cnt_q, clr_cnt_d;
  logic        in_ready_q, in_ready_d;
  logic        oob_q, oob_d;

  logic [10:0] top_off, wrap_pt, phys, rd_addr;
  logic [5:0]  row_sum, phys_row;
  logic [10:0] cur_waddr;
  logic        we, nl, printable;
  logic [10:0] waddr;
  logic [7:0]  wdata, rd_data;

  // Logical-to-physical read address kept within 11 bits by comparing against the wrap point.
  always_comb begin
    top_off = row_off(top_q);
    wrap_pt = 11'(CELLS) - top_off;
    phys    = (pos >= wrap_pt) ? pos - wrap_pt : pos + top_off;
    oob_d   = (pos >= 11'(CELLS));
    rd_addr = oob_d ? 11'd0 : phys;
  end

  always_comb begin
    row_sum   = {1'b0, cur_y_q} + {1'b0, top_q};
    phys_row  = (row_sum >= 6'(ROWS)) ? row_sum - 6'(ROWS) : row_sum;
    cur_waddr = row_off(phys_row[4:0]) + {4'd0, cur_x_q};
    printable = ((in_data >= 8'h20) && (in_data <= 8'h7E)) ||
                ((in_data >= 8'hA0) && (in_data <= 8'hFE));
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d    = state_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    top_d      = top_q;
    clr_addr_d = clr_addr_q;
    clr_cnt_d  = clr_cnt_q;
    we         = 1'b0;
    waddr      = clr_addr_q;
    wdata      = FILL;
    nl         = 1'b0;

    case (state_q)
      CLR_ALL, CLR_ROW: begin
        we = 1'b1;
        if (clr_cnt_q == 11'd0) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d  = clr_cnt_q - 11'd1;
          clr_addr_d = clr_addr_q + 11'd1;
        end
      end
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (in_data == CC_CR) begin
            cur_x_d = 7'd0;
          end else if (in_data == CC_LF) begin
            cur_x_d = 7'd0;
            nl      = 1'b1;
          end else if (in_data == CC_BS) begin
            if (cur_x_q != 7'd0) cur_x_d = cur_x_q - 7'd1;
          end else if (printable) begin
            we    = 1'b1;
            waddr = cur_waddr;
            wdata = in_data;
            if (cur_x_q < 7'(COLS - 1)) begin
              cur_x_d = cur_x_q + 7'd1;
            end else begin
              cur_x_d = 7'd0;
              nl      = 1'b1;
            end
          end
        end
      end
      default: state_d = CLR_ALL;
    endcase

    // Scroll: the old top row becomes the new bottom row and is blanked.
    if (nl) begin
      if (cur_y_q < 5'(ROWS - 1)) begin
        cur_y_d = cur_y_q + 5'd1;
      end else begin
        top_d      = (top_q == 5'(ROWS - 1)) ? 5'd0 : top_q + 5'd1;
        state_d    = CLR_ROW;
        clr_addr_d = top_off;
        clr_cnt_d  = 11'(COLS - 1);
      end
    end

    in_ready_d = (state_d == IDLE);
  end

`ifdef TEXT_TERM_CURSOR_EN
  logic hit_q, hit_d;
  assign hit_d = (pos == row_off(cur_y_q) + {4'd0, cur_x_q});
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLR_ALL;
      cur_x_q    <= 7'd0;
      cur_y_q    <= 5'd0;
      top_q      <= 5'd0;
      clr_addr_q <= 11'd0;
      clr_cnt_q  <= 11'(CELLS - 1);
      in_ready_q <= 1'b0;
      oob_q      <= 1'b1;
`ifdef TEXT_TERM_CURSOR_EN
      hit_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      top_q      <= top_d;
      clr_addr_q <= clr_addr_d;
      clr_cnt_q  <= clr_cnt_d;
      in_ready_q <= in_ready_d;
      oob_q      <= oob_d;
`ifdef TEXT_TERM_CURSOR_EN
      hit_q      <= hit_d;
`endif
    end
  end

  text_ram #(.DEPTH(CELLS), .WIDTH(8), .AW(11)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef TEXT_TERM_CURSOR_EN
  assign char = oob_q ? FILL : (rd_data ^ {hit_q, 7'd0});
`else
  assign char = oob_q ? FILL : rd_data;
`endif

  assign in_ready = in_ready_q;
  assign cur_x    = cur_x_q;
  assign cur_y    = cur_y_q;

endmodule
